// File: rtl/silife_max7219.sv
// MAX7219 display stage: streams the SiLife cell matrix, one row per SPI word,
// after a one-time init sequence, refreshing whole frames while enabled.
module silife_max7219 #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int CLK_DIV = 4,
  localparam int RSW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       brightness,
  output logic [RSW-1:0]   row_select,
  input  logic [WIDTH-1:0] cells,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic             busy,
  output logic             frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0] ROWS = 4'(HEIGHT);

  if (WIDTH != 8 || HEIGHT < 1 || HEIGHT > 8 || CLK_DIV < 1) begin : g_bad_params
    $error("silife_max7219: WIDTH must be 8, HEIGHT 1..8, CLK_DIV >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [3:0]     bit_q, bit_d;
  logic           phase_q, phase_d;
  logic [15:0]    sr_q, sr_d;
  logic [3:0]     word_idx_q, word_idx_d;
  logic           init_done_q, init_done_d;
  logic [RSW-1:0] row_select_q, row_select_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    load_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      sr_q         <= '0;
      word_idx_q   <= '0;
      init_done_q  <= 1'b0;
      row_select_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      sr_q         <= sr_d;
      word_idx_q   <= word_idx_d;
      init_done_q  <= init_done_d;
      row_select_q <= row_select_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Word for the current index; intensity is captured from brightness here, at its LOAD.
  always_comb begin
    load_word = 16'h0F00;
    if (!init_done_q) begin
      case (word_idx_q)
        4'd0:    load_word = 16'h0C01;
        4'd1:    load_word = 16'h0900;
        4'd2:    load_word = {8'h0B, 8'(HEIGHT - 1)};
        default: load_word = 16'h0F00;
      endcase
    end else if (word_idx_q == 4'd0) begin
      load_word = {8'h0A, 4'h0, brightness};
    end else begin
      load_word = {4'h0, word_idx_q, cells};
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    sr_d         = sr_q;
    word_idx_d   = word_idx_q;
    init_done_d  = init_done_q;
    row_select_d = row_select_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        row_select_d = '0;
        if (enable) begin
          state_d    = S_LOAD;
          word_idx_d = 4'd0;
        end
      end
      S_LOAD: begin
        sr_d    = load_word;
        div_d   = '0;
        bit_d   = 4'd0;
        phase_d = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 4'd15) begin
            phase_d = 1'b0;
            state_d = S_LATCH;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 4'd1;
            sr_d    = {sr_q[14:0], 1'b0};
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_GAP;
          // Row r is word r+1, so the next word's row equals the current index.
          if (init_done_q && word_idx_q < ROWS) begin
            row_select_d = word_idx_q[RSW-1:0];
          end else begin
            row_select_d = '0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!init_done_q) begin
            if (word_idx_q == 4'd3) begin
              init_done_d = 1'b1;
              word_idx_d  = 4'd0;
              state_d     = enable ? S_LOAD : S_IDLE;
            end else begin
              word_idx_d = word_idx_q + 4'd1;
              state_d    = S_LOAD;
            end
          end else if (word_idx_q == ROWS) begin
            frame_done_d = 1'b1;
            word_idx_d   = 4'd0;
            state_d      = enable ? S_LOAD : S_IDLE;
          end else if (enable) begin
            word_idx_d = word_idx_q + 4'd1;
            state_d    = S_LOAD;
          end else begin
            word_idx_d = 4'd0;
            state_d    = S_IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit 15 of every word is zero, so MOSI can stay low during LOAD.
  always_comb begin
    spi_cs_n   = !(state_q == S_LOAD || state_q == S_SHIFT || state_q == S_LATCH);
    spi_sck    = (state_q == S_SHIFT) && phase_q;
    spi_mosi   = (state_q == S_SHIFT || state_q == S_LATCH) ? sr_q[15] : 1'b0;
    busy       = (state_q != S_IDLE);
    frame_done = frame_done_q;
    row_select = row_select_q;
  end

endmodule
